irrigation_countdown: RTL and testbench



---
 rtl/irrigation_countdown.sv | 158 +++++++++++++++
 tb/tb_irrigation_countdown.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/irrigation_countdown.sv
// Loadable MM:SS BCD countdown with IDLE/RUN/PAUSED/DONE control; digits decrement one second per tick in RUN.
// Latency: commands and ticks are visible one cycle later; no input backpressure (abort > load > start > pause/tick).
module irrigation_countdown #(
    parameter int MAX_MIN_TENS = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       load,
    input  logic       start,
    input  logic       abort,
    input  logic       pause_us,
    input  logic       pause_alin,
    input  logic [3:0] preset_mt,
    input  logic [3:0] preset_mu,
    input  logic [3:0] preset_st,
    input  logic [3:0] preset_su,
    output logic [3:0] min_tens,
    output logic [3:0] min_units,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_units,
    output logic       reach_zero,
    output logic       running,
    output logic       paused,
    output logic       done,
    output logic       load_err
);

    localparam logic [3:0] MT_MAX = 4'(MAX_MIN_TENS);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_PAUSED = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] mt_q, mt_d, mu_q, mu_d, st_q, st_d, su_q, su_d;
    logic       reach_zero_q, reach_zero_d;
    logic       done_q, done_d;
    logic       load_err_q, load_err_d;

    logic pause_req;
    logic count_zero;
    logic count_one;
    logic preset_ok;

    assign pause_req  = pause_us | pause_alin;
    assign count_zero = (mt_q == 4'd0) && (mu_q == 4'd0) && (st_q == 4'd0) && (su_q == 4'd0);
    assign count_one  = (mt_q == 4'd0) && (mu_q == 4'd0) && (st_q == 4'd0) && (su_q == 4'd1);
    assign preset_ok  = (preset_mt <= MT_MAX) && (preset_mu <= 4'd9) &&
                        (preset_st <= 4'd5) && (preset_su <= 4'd9);

    always_comb begin
        state_d    = state_q;
        mt_d       = mt_q;
        mu_d       = mu_q;
        st_d       = st_q;
        su_d       = su_q;
        done_d     = 1'b0;
        load_err_d = 1'b0;

        if (abort) begin
            mt_d    = 4'd0;
            mu_d    = 4'd0;
            st_d    = 4'd0;
            su_d    = 4'd0;
            state_d = S_IDLE;
        end else if (load) begin
            if (preset_ok) begin
                mt_d    = preset_mt;
                mu_d    = preset_mu;
                st_d    = preset_st;
                su_d    = preset_su;
                state_d = S_IDLE;
            end else begin
                load_err_d = 1'b1;
            end
        end else if (start && (state_q == S_IDLE) && !count_zero) begin
            state_d = pause_req ? S_PAUSED : S_RUN;
        end else begin
            case (state_q)
                S_RUN: begin
                    // A pause request swallows a coincident tick.
                    if (pause_req) begin
                        state_d = S_PAUSED;
                    end else if (tick && !count_zero) begin
                        if (su_q != 4'd0) begin
                            su_d = su_q - 4'd1;
                        end else begin
                            su_d = 4'd9;
                            if (st_q != 4'd0) begin
                                st_d = st_q - 4'd1;
                            end else begin
                                st_d = 4'd5;
                                if (mu_q != 4'd0) begin
                                    mu_d = mu_q - 4'd1;
                                end else begin
                                    mu_d = 4'd9;
                                    mt_d = mt_q - 4'd1;
                                end
                            end
                        end
                        if (count_one) begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                        end
                    end
                end
                S_PAUSED: begin
                    if (!pause_req) begin
                        state_d = S_RUN;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end

        // Registered alongside the digits so it always matches what is displayed.
        reach_zero_d = (mt_d == 4'd0) && (mu_d == 4'd0) && (st_d == 4'd0) && (su_d == 4'd0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            mt_q         <= 4'd0;
            mu_q         <= 4'd0;
            st_q         <= 4'd0;
            su_q         <= 4'd0;
            reach_zero_q <= 1'b1;
            done_q       <= 1'b0;
            load_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            mt_q         <= mt_d;
            mu_q         <= mu_d;
            st_q         <= st_d;
            su_q         <= su_d;
            reach_zero_q <= reach_zero_d;
            done_q       <= done_d;
            load_err_q   <= load_err_d;
        end
    end

    assign min_tens   = mt_q;
    assign min_units  = mu_q;
    assign sec_tens   = st_q;
    assign sec_units  = su_q;
    assign reach_zero = reach_zero_q;
    assign running    = (state_q == S_RUN);
    assign paused     = (state_q == S_PAUSED);
    assign done       = done_q;
    assign load_err   = load_err_q;

endmodule

// File: tb/tb_irrigation_countdown.sv
// Directed bench for irrigation_countdown: one task per scenario, expected values hand-computed.
module tb_irrigation_countdown;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick = 1'b0, load = 1'b0, start = 1'b0, abort = 1'b0;
    logic       pause_us = 1'b0, pause_alin = 1'b0;
    logic [3:0] preset_mt = 4'd0, preset_mu = 4'd0, preset_st = 4'd0, preset_su = 4'd0;
    logic [3:0] min_tens, min_units, sec_tens, sec_units;
    logic       reach_zero, running, paused, done, load_err;

    int n_checks = 0;
    int n_fail   = 0;

    irrigation_countdown #(.MAX_MIN_TENS(5)) dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .load(load), .start(start), .abort(abort),
        .pause_us(pause_us), .pause_alin(pause_alin),
        .preset_mt(preset_mt), .preset_mu(preset_mu), .preset_st(preset_st), .preset_su(preset_su),
        .min_tens(min_tens), .min_units(min_units), .sec_tens(sec_tens), .sec_units(sec_units),
        .reach_zero(reach_zero), .running(running), .paused(paused), .done(done), .load_err(load_err)
    );

    always #5 clk = ~clk;

    wire [15:0] cnt = {min_tens, min_units, sec_tens, sec_units};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [15:0] v);
        {preset_mt, preset_mu, preset_st, preset_su} = v;
        load = 1'b1;
        step();
        load = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic do_tick();
        tick = 1'b1;
        step();
        tick = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        n_checks++; if (cnt !== 16'h0000) begin n_fail++; $display("FAIL reset_cnt got %h want 0000", cnt); end
        n_checks++; if (reach_zero !== 1'b1) begin n_fail++; $display("FAIL reset_rz got %b want 1", reach_zero); end
        n_checks++; if ({running, paused, done, load_err} !== 4'b0000) begin n_fail++; $display("FAIL reset_flags got %b want 0000", {running, paused, done, load_err}); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_terminal();
        do_load(16'h0003);
        n_checks++; if (cnt !== 16'h0003 || reach_zero !== 1'b0) begin n_fail++; $display("FAIL t1_load got %h rz=%b want 0003 rz=0", cnt, reach_zero); end
        do_start();
        n_checks++; if (running !== 1'b1) begin n_fail++; $display("FAIL t1_running got %b want 1", running); end
        do_tick();
        n_checks++; if (cnt !== 16'h0002) begin n_fail++; $display("FAIL t1_tick1 got %h want 0002", cnt); end
        do_tick();
        n_checks++; if (cnt !== 16'h0001 || done !== 1'b0) begin n_fail++; $display("FAIL t1_tick2 got %h done=%b want 0001 done=0", cnt, done); end
        do_tick();
        n_checks++; if (cnt !== 16'h0000) begin n_fail++; $display("FAIL t1_tick3 got %h want 0000", cnt); end
        n_checks++; if ({done, reach_zero, running} !== 3'b110) begin n_fail++; $display("FAIL t1_done got d/rz/run=%b want 110", {done, reach_zero, running}); end
        step();
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL t1_done_pulse got %b want 0", done); end
        do_start();
        n_checks++; if (running !== 1'b0 || cnt !== 16'h0000) begin n_fail++; $display("FAIL t1_start_in_done got run=%b cnt=%h want 0 0000", running, cnt); end
    endtask

    task automatic test_borrow();
        do_load(16'h1000);
        do_start();
        do_tick();
        n_checks++; if (cnt !== 16'h0959) begin n_fail++; $display("FAIL t2_borrow10 got %h want 0959", cnt); end
        do_load(16'h0100);
        n_checks++; if (running !== 1'b0 || cnt !== 16'h0100) begin n_fail++; $display("FAIL t2_load_in_run got run=%b cnt=%h want 0 0100", running, cnt); end
        do_start();
        do_tick();
        n_checks++; if (cnt !== 16'h0059) begin n_fail++; $display("FAIL t2_borrow01 got %h want 0059", cnt); end
    endtask

    task automatic test_pause();
        do_load(16'h0530);
        do_start();
        tick = 1'b1; pause_us = 1'b1;
        step();
        tick = 1'b0;
        n_checks++; if (paused !== 1'b1 || running !== 1'b0 || cnt !== 16'h0530) begin n_fail++; $display("FAIL t3_pause got p=%b r=%b cnt=%h want 1 0 0530", paused, running, cnt); end
        do_tick();
        do_tick();
        n_checks++; if (cnt !== 16'h0530 || paused !== 1'b1) begin n_fail++; $display("FAIL t3_tick_paused got %h p=%b want 0530 1", cnt, paused); end
        pause_us = 1'b0;
        step();
        n_checks++; if (running !== 1'b1 || paused !== 1'b0) begin n_fail++; $display("FAIL t3_resume got r=%b p=%b want 1 0", running, paused); end
        do_tick();
        n_checks++; if (cnt !== 16'h0529) begin n_fail++; $display("FAIL t3_after_resume got %h want 0529", cnt); end
    endtask

    task automatic test_start_paused();
        do_load(16'h0010);
        pause_alin = 1'b1;
        do_start();
        n_checks++; if (paused !== 1'b1 || running !== 1'b0) begin n_fail++; $display("FAIL t3b_start_paused got p=%b r=%b want 1 0", paused, running); end
        pause_alin = 1'b0;
        step();
        n_checks++; if (running !== 1'b1) begin n_fail++; $display("FAIL t3b_release got r=%b want 1", running); end
    endtask

    task automatic test_load_err();
        do_load(16'h0245);
        do_start();
        do_load(16'h0160);
        n_checks++; if (load_err !== 1'b1 || cnt !== 16'h0245 || running !== 1'b1) begin n_fail++; $display("FAIL t4_bad_st got err=%b cnt=%h r=%b want 1 0245 1", load_err, cnt, running); end
        step();
        n_checks++; if (load_err !== 1'b0) begin n_fail++; $display("FAIL t4_err_pulse got %b want 0", load_err); end
        do_load(16'h6000);
        n_checks++; if (load_err !== 1'b1 || cnt !== 16'h0245) begin n_fail++; $display("FAIL t4_bad_mt got err=%b cnt=%h want 1 0245", load_err, cnt); end
        do_load(16'h5959);
        n_checks++; if (load_err !== 1'b0 || cnt !== 16'h5959) begin n_fail++; $display("FAIL t4_max_ok got err=%b cnt=%h want 0 5959", load_err, cnt); end
        do_load(16'h0000);
        do_start();
        n_checks++; if (running !== 1'b0 || paused !== 1'b0 || reach_zero !== 1'b1) begin n_fail++; $display("FAIL t4_start_zero got r=%b p=%b rz=%b want 0 0 1", running, paused, reach_zero); end
    endtask

    task automatic test_abort();
        do_load(16'h0215);
        do_start();
        abort = 1'b1; load = 1'b1;
        {preset_mt, preset_mu, preset_st, preset_su} = 16'h0400;
        step();
        abort = 1'b0; load = 1'b0;
        n_checks++; if (cnt !== 16'h0000 || running !== 1'b0 || reach_zero !== 1'b1) begin n_fail++; $display("FAIL t5_abort got cnt=%h r=%b rz=%b want 0000 0 1", cnt, running, reach_zero); end
        do_load(16'h0001);
        do_start();
        do_tick();
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL t5_reach_done got %b want 1", done); end
        do_load(16'h0400);
        n_checks++; if (cnt !== 16'h0400 || reach_zero !== 1'b0 || running !== 1'b0) begin n_fail++; $display("FAIL t5_load_in_done got cnt=%h rz=%b r=%b want 0400 0 0", cnt, reach_zero, running); end
        do_start();
        n_checks++; if (running !== 1'b1) begin n_fail++; $display("FAIL t5_idle_start got %b want 1", running); end
        abort = 1'b1;
        step();
        abort = 1'b0;
    endtask

    task automatic test_async_reset();
        do_load(16'h0307);
        do_start();
        n_checks++; if (running !== 1'b1 || cnt !== 16'h0307) begin n_fail++; $display("FAIL t6_pre got r=%b cnt=%h want 1 0307", running, cnt); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (cnt !== 16'h0000 || reach_zero !== 1'b1 || running !== 1'b0) begin n_fail++; $display("FAIL t6_async got cnt=%h rz=%b r=%b want 0000 1 0", cnt, reach_zero, running); end
        #2 rst_n = 1'b1;
        step();
        do_start();
        n_checks++; if (running !== 1'b0 || cnt !== 16'h0000) begin n_fail++; $display("FAIL t6_start_after got r=%b cnt=%h want 0 0000", running, cnt); end
    endtask

    initial begin
        test_reset();
        test_terminal();
        test_borrow();
        test_pause();
        test_start_paused();
        test_load_err();
        test_abort();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
